// File: rtl/fault_inject_ctrl.sv
// rtl/fault_inject_ctrl.sv - single-fault campaign sequencer for injection_module
module fault_inject_ctrl #(
  parameter int N_TGT   = 6,
  parameter int CNT_W   = 16,
  parameter int OBS_CYC = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [2:0]       cfg_tgt,
  input  logic [1:0]       cfg_mode,
  input  logic [CNT_W-1:0] cfg_delay,
  input  logic [CNT_W-1:0] cfg_len,
  input  logic             abort,
  input  logic [N_TGT-1:0] clean_in,
  output logic [N_TGT-1:0] faulty_out,
  input  logic [1:0]       golden_y,
  input  logic [1:0]       dut_y,
  output logic             inj_active,
  output logic             done,
  output logic             detected,
  output logic [CNT_W-1:0] det_lat,
  output logic             cfg_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_INJECT,
    S_OBSERVE,
    S_REPORT
  } state_t;

  localparam logic [1:0]       MODE_SA0  = 2'b00;
  localparam logic [1:0]       MODE_SA1  = 2'b01;
  localparam logic [1:0]       MODE_FLIP = 2'b10;
  localparam logic [1:0]       MODE_RSVD = 2'b11;
  localparam logic [3:0]       TGT_LIM   = 4'(N_TGT);
  localparam logic [CNT_W-1:0] OBS_LAST  = CNT_W'(OBS_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] lat_cnt;
  logic [CNT_W-1:0] len_q;
  logic [2:0]       tgt_q;
  logic [1:0]       mode_q;

  logic             cfg_bad;
  logic             mismatch;
  logic [CNT_W-1:0] len_last;

  // descriptor screening, output comparison and the zero-length-as-one rule
  always_comb begin
    cfg_bad  = ({1'b0, cfg_tgt} >= TGT_LIM) || (cfg_mode == MODE_RSVD);
    mismatch = (dut_y != golden_y);
    len_last = (len_q == '0) ? '0 : (len_q - CNT_ONE);
  end

  // corruption is keyed off the registered inj_active so abort/reset remove it on the same edge
  always_comb begin
    faulty_out = clean_in;
    if (inj_active) begin
      case (mode_q)
        MODE_SA0:  faulty_out[tgt_q] = 1'b0;
        MODE_SA1:  faulty_out[tgt_q] = 1'b1;
        MODE_FLIP: faulty_out[tgt_q] = ~clean_in[tgt_q];
        default:   faulty_out[tgt_q] = clean_in[tgt_q];
      endcase
    end
  end

  // campaign sequencer with registered status outputs and the shared down-counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cfg_ready  <= 1'b1;
      inj_active <= 1'b0;
      done       <= 1'b0;
      detected   <= 1'b0;
      det_lat    <= '0;
      cfg_err    <= 1'b0;
      cnt        <= '0;
      lat_cnt    <= '0;
      len_q      <= '0;
      tgt_q      <= '0;
      mode_q     <= '0;
    end else begin
      done <= 1'b0;

      // first mismatch in the inject/observe window freezes the latency
      if ((state == S_INJECT) || (state == S_OBSERVE)) begin
        if (mismatch && !detected) begin
          detected <= 1'b1;
          det_lat  <= lat_cnt;
        end
        if (lat_cnt != CNT_MAX) begin
          lat_cnt <= lat_cnt + CNT_ONE;
        end
      end

      case (state)
        S_IDLE: begin
          if (cfg_valid && cfg_ready) begin
            tgt_q     <= cfg_tgt;
            mode_q    <= cfg_mode;
            len_q     <= cfg_len;
            cnt       <= cfg_delay;
            detected  <= 1'b0;
            det_lat   <= '0;
            cfg_err   <= cfg_bad;
            cfg_ready <= 1'b0;
            if (cfg_bad) begin
              state <= S_REPORT;
              done  <= 1'b1;
            end else begin
              state <= S_WAIT;
            end
          end
        end

        S_WAIT: begin
          if (abort) begin
            state     <= S_IDLE;
            cfg_ready <= 1'b1;
          end else if (cnt == '0) begin
            state      <= S_INJECT;
            inj_active <= 1'b1;
            cnt        <= len_last;
            lat_cnt    <= '0;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end

        S_INJECT: begin
          if (abort) begin
            state      <= S_IDLE;
            inj_active <= 1'b0;
            cfg_ready  <= 1'b1;
          end else if (cnt == '0) begin
            state      <= S_OBSERVE;
            inj_active <= 1'b0;
            cnt        <= OBS_LAST;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end

        S_OBSERVE: begin
          if (abort) begin
            state     <= S_IDLE;
            cfg_ready <= 1'b1;
          end else if (cnt == '0) begin
            state <= S_REPORT;
            done  <= 1'b1;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end

        S_REPORT: begin
          state     <= S_IDLE;
          cfg_ready <= 1'b1;
        end

        default: begin
          state      <= S_IDLE;
          inj_active <= 1'b0;
          cfg_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fault_inject_ctrl.sv
// tb/tb_fault_inject_ctrl.sv - scoreboard bench for fault_inject_ctrl
module tb_fault_inject_ctrl;
  localparam int N_TGT   = 6;
  localparam int CNT_W   = 16;
  localparam int OBS_CYC = 8;
  localparam int NEVER   = 1000000000;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cfg_valid = 1'b0;
  logic             cfg_ready;
  logic [2:0]       cfg_tgt = '0;
  logic [1:0]       cfg_mode = '0;
  logic [CNT_W-1:0] cfg_delay = '0;
  logic [CNT_W-1:0] cfg_len = '0;
  logic             abort = 1'b0;
  logic [N_TGT-1:0] clean_in = 6'h15;
  logic [N_TGT-1:0] faulty_out;
  logic [1:0]       golden_y = '0;
  logic [1:0]       dut_y = '0;
  logic             inj_active;
  logic             done;
  logic             detected;
  logic [CNT_W-1:0] det_lat;
  logic             cfg_err;

  fault_inject_ctrl #(.N_TGT(N_TGT), .CNT_W(CNT_W), .OBS_CYC(OBS_CYC)) dut (
    .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_tgt(cfg_tgt), .cfg_mode(cfg_mode), .cfg_delay(cfg_delay), .cfg_len(cfg_len),
    .abort(abort), .clean_in(clean_in), .faulty_out(faulty_out),
    .golden_y(golden_y), .dut_y(dut_y), .inj_active(inj_active), .done(done),
    .detected(detected), .det_lat(det_lat), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  typedef struct {
    int          done_cyc;
    logic        det;
    logic [15:0] lat;
    logic        err;
  } exp_t;
  exp_t sb[$];

  // reference model of the corruption window and mismatch stimulus
  int         win_lo = NEVER;
  int         win_hi = -1;
  logic [2:0] win_tgt = '0;
  logic [1:0] win_mode = '0;
  int         mis_lo = NEVER;
  int         mis_hi = -1;
  bit         env_rand = 0;

  always @(negedge clk) begin
    logic [N_TGT-1:0] exp_f;
    logic             in_win;
    exp_t             e;
    if (env_rand) clean_in = 6'($urandom_range(0, 63));
    golden_y = 2'($urandom_range(0, 3));
    dut_y = golden_y ^ (((cyc >= mis_lo) && (cyc <= mis_hi)) ? 2'b10 : 2'b00);
    #1;
    in_win = (cyc >= win_lo) && (cyc <= win_hi);
    exp_f = clean_in;
    if (in_win) begin
      case (win_mode)
        2'b00:   exp_f[win_tgt] = 1'b0;
        2'b01:   exp_f[win_tgt] = 1'b1;
        default: exp_f[win_tgt] = ~clean_in[win_tgt];
      endcase
    end
    chk("faulty_out", faulty_out, exp_f);
    chk("inj_active", inj_active, in_win);
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("done_cyc", cyc, e.done_cyc);
        chk("detected", detected, e.det);
        chk("det_lat", det_lat, e.lat);
        chk("cfg_err", cfg_err, e.err);
      end
    end
  end

  // issue one descriptor; mrel_* are mismatch cycles relative to the first inject cycle (-1 = none)
  task automatic start(input int tgt, input int mode, input int delay, input int len,
                       input int mrel_lo, input int mrel_hi);
    exp_t e;
    int   acc;
    int   leff;
    bit   isbad;
    chk("cfg_ready_pre", cfg_ready, 1);
    cfg_tgt   = 3'(tgt);
    cfg_mode  = 2'(mode);
    cfg_delay = 16'(delay);
    cfg_len   = 16'(len);
    cfg_valid = 1'b1;
    acc   = cyc + 1;
    isbad = (tgt >= N_TGT) || (mode == 3);
    leff  = (len == 0) ? 1 : len;
    mis_lo = NEVER;
    mis_hi = -1;
    if (isbad) begin
      e.done_cyc = acc;
      e.det = 1'b0;
      e.lat = '0;
      e.err = 1'b1;
    end else begin
      win_lo   = acc + delay + 1;
      win_hi   = win_lo + leff - 1;
      win_tgt  = 3'(tgt);
      win_mode = 2'(mode);
      if (mrel_lo >= 0) begin
        mis_lo = win_lo + mrel_lo;
        mis_hi = win_lo + mrel_hi;
      end
      e.done_cyc = win_lo + leff + OBS_CYC;
      e.det = (mrel_lo >= 0) && (mrel_lo <= leff + OBS_CYC - 1);
      e.lat = e.det ? 16'(mrel_lo) : 16'd0;
      e.err = 1'b0;
    end
    sb.push_back(e);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (sb.size() != 0) begin
      chk("timeout_done", 0, 1);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic wait_cyc(input int target);
    int n = 0;
    while (cyc != target && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (cyc != target) chk("timeout_cyc", cyc, target);
  endtask

  initial begin
    rst = 1'b1;
    clean_in = 6'h15;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    chk("rst_faulty_out", faulty_out, 6'h15);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_inj_active", inj_active, 0);
    chk("rst_done", done, 0);
    chk("rst_detected", detected, 0);
    chk("rst_det_lat", det_lat, 0);
    chk("rst_cfg_err", cfg_err, 0);
    @(negedge clk);
    rst = 1'b0;
    env_rand = 1;

    // abort while idle is ignored
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    @(negedge clk);
    chk("idle_abort_ready", cfg_ready, 1);

    // stuck-at-1 on c, no mismatch; a descriptor offered mid-campaign must be ignored
    start(2, 1, 3, 4, -1, -1);
    repeat (3) @(negedge clk);
    cfg_tgt = 3'd7;
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    wait_done();

    // bit-flip on a, mismatch on the 4th window cycle
    start(0, 2, 0, 2, 3, 3);
    wait_done();

    // rejected descriptors
    start(7, 0, 2, 2, -1, -1);
    wait_done();
    start(1, 3, 2, 2, -1, -1);
    wait_done();

    // abort two cycles into INJECT, then an immediate new campaign
    start(4, 0, 2, 6, -1, -1);
    wait_cyc(win_lo + 2);
    abort = 1'b1;
    win_hi = cyc;
    void'(sb.pop_back());
    @(negedge clk);
    abort = 1'b0;
    chk("abort_ready", cfg_ready, 1);
    start(5, 1, 1, 3, 1, 100);
    wait_done();

    // reset in the middle of INJECT, then an immediate new campaign with len=0
    start(3, 2, 1, 5, 0, 0);
    wait_cyc(win_lo + 1);
    rst = 1'b1;
    win_hi = cyc;
    mis_lo = NEVER;
    mis_hi = -1;
    void'(sb.pop_back());
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_ready", cfg_ready, 1);
    chk("midrst_detected", detected, 0);
    chk("midrst_det_lat", det_lat, 0);
    start(1, 1, 0, 0, 0, 1000);
    wait_done();

    // a few randomized campaigns, mismatch sometimes beyond the window
    for (int i = 0; i < 5; i++) begin
      int ln;
      int mr;
      ln = $urandom_range(0, 5);
      mr = $urandom_range(0, ((ln == 0) ? 1 : ln) + OBS_CYC + 2);
      start($urandom_range(0, 5), $urandom_range(0, 2), $urandom_range(0, 5), ln, mr, mr);
      wait_done();
    end

    chk("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0d exp=finish", cyc);
    $fatal(1);
  end

endmodule
